// File: rtl/data_mem_lsu.sv
// Byte-addressable single-port data memory with an RV32I load/store formatter,
// valid/ready request handshake, 1- or 2-cycle response latency and error detection.
module data_mem_lsu #(
  parameter int N_WORD   = 1024,
  parameter int ADDR_W   = 12,
  parameter int DATA_LEN = 32,
  parameter int RD_LAT   = 1
) (
  input  logic                d_clk,
  input  logic                d_rst_n,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic                d_we,
  input  logic [2:0]          d_funct3,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_LEN-1:0] d_w_data,
  output logic                d_rsp_valid,
  output logic [DATA_LEN-1:0] d_r_data,
  output logic                d_err
);

  if (ADDR_W != $clog2(N_WORD) + 2) begin : g_bad_addr_w
    $error("data_mem_lsu: ADDR_W must equal log2(N_WORD)+2");
  end
  if ((N_WORD & (N_WORD - 1)) != 0) begin : g_bad_n_word
    $error("data_mem_lsu: N_WORD must be a power of two");
  end
  if (DATA_LEN != 32) begin : g_bad_data_len
    $error("data_mem_lsu: only DATA_LEN=32 is supported");
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
    $error("data_mem_lsu: RD_LAT must be 1 or 2");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  lat_cnt_q, lat_cnt_d;
  logic [DATA_LEN-1:0]   pend_data_q, rdata_q;
  logic                  pend_err_q, err_q;

  logic [DATA_LEN-1:0]   mem [N_WORD];
  logic [ADDR_W-3:0]     idx;
  logic [1:0]            off;
  logic                  accept;
  logic                  illegal, misalign, req_err;
  logic [3:0]            wr_be;
  logic [DATA_LEN-1:0]   wr_data, rd_word, rd_shift, fmt_data;

  assign idx    = d_addr[ADDR_W-1:2];
  assign off    = d_addr[1:0];
  assign accept = d_req_valid && ready_q;

  // funct3[1:0]=11 is never legal; funct3[2] marks the unsigned loads only.
  always_comb begin
    illegal  = (d_funct3[1:0] == 2'b11) || (d_funct3[2] && (d_funct3[1] || d_we));
    misalign = ((d_funct3[1:0] == 2'b01) && off[0]) ||
               ((d_funct3[1:0] == 2'b10) && (off != 2'b00));
    req_err  = illegal || misalign;
  end

  always_comb begin
    wr_be   = 4'b0000;
    wr_data = '0;
    case (d_funct3[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << off;
        wr_data = {4{d_w_data[7:0]}};
      end
      2'b01: begin
        wr_be   = off[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{d_w_data[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = d_w_data;
      end
    endcase
  end

  always_comb begin
    rd_word  = mem[idx];
    rd_shift = rd_word >> {off, 3'b000};
    fmt_data = rd_word;
    case (d_funct3[1:0])
      2'b00:   fmt_data = {{24{~d_funct3[2] & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   fmt_data = {{16{~d_funct3[2] & rd_shift[15]}}, rd_shift[15:0]};
      default: fmt_data = rd_word;
    endcase
    if (d_we || req_err) fmt_data = '0;
  end

  always_ff @(posedge d_clk) begin
    if (accept && d_we && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          if (RD_LAT == 1) begin
            state_d = RESP;
          end else begin
            state_d   = BUSY;
            lat_cnt_d = 1'(RD_LAT - 1);
          end
        end else if (state_q == RESP) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        lat_cnt_d = lat_cnt_q - 1'b1;
        if (lat_cnt_q == 1'b1) state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d != BUSY);
  end

  // Output registers only change when a new response is presented, so they hold otherwise.
  always_ff @(posedge d_clk or negedge d_rst_n) begin
    if (!d_rst_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      lat_cnt_q   <= 1'b0;
      pend_data_q <= '0;
      pend_err_q  <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      lat_cnt_q <= lat_cnt_d;
      if (accept) begin
        pend_data_q <= fmt_data;
        pend_err_q  <= req_err;
      end
      if (RD_LAT == 1) begin
        if (accept) begin
          rdata_q <= fmt_data;
          err_q   <= req_err;
        end
      end else if (state_q == BUSY && state_d == RESP) begin
        rdata_q <= pend_data_q;
        err_q   <= pend_err_q;
      end
    end
  end

  assign d_req_ready = ready_q;
  assign d_rsp_valid = (state_q == RESP);
  assign d_r_data    = rdata_q;
  assign d_err       = err_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: one instance at RD_LAT=1 (unit 0), one at RD_LAT=2 (unit 1).
module tb_data_mem_lsu;

  logic        clk;
  logic        rst_n;
  logic        valid [2];
  logic        ready [2];
  logic        we    [2];
  logic [2:0]  f3    [2];
  logic [11:0] addr  [2];
  logic [31:0] wdata [2];
  logic        rsp   [2];
  logic [31:0] rdata [2];
  logic        err   [2];

  int checks;
  int failures;

  data_mem_lsu #(.N_WORD(1024), .ADDR_W(12), .DATA_LEN(32), .RD_LAT(1)) dut0 (
    .d_clk(clk), .d_rst_n(rst_n), .d_req_valid(valid[0]), .d_req_ready(ready[0]),
    .d_we(we[0]), .d_funct3(f3[0]), .d_addr(addr[0]), .d_w_data(wdata[0]),
    .d_rsp_valid(rsp[0]), .d_r_data(rdata[0]), .d_err(err[0])
  );

  data_mem_lsu #(.N_WORD(1024), .ADDR_W(12), .DATA_LEN(32), .RD_LAT(2)) dut1 (
    .d_clk(clk), .d_rst_n(rst_n), .d_req_valid(valid[1]), .d_req_ready(ready[1]),
    .d_we(we[1]), .d_funct3(f3[1]), .d_addr(addr[1]), .d_w_data(wdata[1]),
    .d_rsp_valid(rsp[1]), .d_r_data(rdata[1]), .d_err(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic drive(input int u, input logic w, input logic [2:0] f, input logic [11:0] a,
                       input logic [31:0] d);
    valid[u] = 1'b1;
    we[u]    = w;
    f3[u]    = f;
    addr[u]  = a;
    wdata[u] = d;
  endtask

  // One request: drive, wait for accept, return response and accept-to-response edge count.
  task automatic xact(input int u, input logic w, input logic [2:0] f, input logic [11:0] a,
                      input logic [31:0] d, output logic [31:0] rd, output logic er,
                      output int lat);
    int n;
    @(negedge clk);
    drive(u, w, f, a, d);
    n = 0;
    while (ready[u] !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    valid[u] = 1'b0;
    lat = 1;
    while (rsp[u] !== 1'b1 && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd = rdata[u];
    er = err[u];
  endtask

  task automatic test_reset();
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (ready[u] !== 1'b0 || rsp[u] !== 1'b0 || rdata[u] !== 32'h0 || err[u] !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs u=%0d got ready=%b rsp=%b rdata=%h err=%b exp all 0",
                 u, ready[u], rsp[u], rdata[u], err[u]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (ready[u] !== 1'b1 || rsp[u] !== 1'b0) begin
        failures++;
        $display("FAIL reset_release u=%0d got ready=%b rsp=%b exp ready=1 rsp=0",
                 u, ready[u], rsp[u]);
      end
    end
  endtask

  task automatic test_word(input int u);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(u, 1'b1, 3'b010, 12'h010, 32'hDEADBEEF, rd, er, lat);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0 || lat != u + 1) begin
      failures++;
      $display("FAIL sw_word u=%0d got rdata=%h err=%b lat=%0d exp 0/0/%0d", u, rd, er, lat, u + 1);
    end
    xact(u, 1'b0, 3'b010, 12'h010, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat != u + 1) begin
      failures++;
      $display("FAIL lw_word u=%0d got rdata=%h err=%b lat=%0d exp deadbeef/0/%0d",
               u, rd, er, lat, u + 1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rsp[u] !== 1'b0 || rdata[u] !== 32'hDEADBEEF || err[u] !== 1'b0) begin
      failures++;
      $display("FAIL rsp_hold u=%0d got rsp=%b rdata=%h err=%b exp 0/deadbeef/0",
               u, rsp[u], rdata[u], err[u]);
    end
  endtask

  task automatic test_byte(input int u);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(u, 1'b1, 3'b010, 12'h010, 32'h00000000, rd, er, lat);
    xact(u, 1'b1, 3'b000, 12'h013, 32'h12345680, rd, er, lat);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      failures++;
      $display("FAIL sb u=%0d got rdata=%h err=%b exp 0/0", u, rd, er);
    end
    xact(u, 1'b0, 3'b000, 12'h013, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin
      failures++;
      $display("FAIL lb u=%0d got rdata=%h err=%b exp ffffff80/0", u, rd, er);
    end
    xact(u, 1'b0, 3'b100, 12'h013, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h00000080 || er !== 1'b0) begin
      failures++;
      $display("FAIL lbu u=%0d got rdata=%h err=%b exp 00000080/0", u, rd, er);
    end
    xact(u, 1'b0, 3'b010, 12'h010, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h80000000 || er !== 1'b0) begin
      failures++;
      $display("FAIL lw_after_sb u=%0d got rdata=%h err=%b exp 80000000/0", u, rd, er);
    end
  endtask

  task automatic test_half(input int u);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(u, 1'b1, 3'b010, 12'h020, 32'h11223344, rd, er, lat);
    xact(u, 1'b1, 3'b001, 12'h022, 32'hAAAA8001, rd, er, lat);
    xact(u, 1'b0, 3'b001, 12'h022, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFF8001 || er !== 1'b0) begin
      failures++;
      $display("FAIL lh u=%0d got rdata=%h err=%b exp ffff8001/0", u, rd, er);
    end
    xact(u, 1'b0, 3'b101, 12'h022, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h00008001 || er !== 1'b0) begin
      failures++;
      $display("FAIL lhu u=%0d got rdata=%h err=%b exp 00008001/0", u, rd, er);
    end
    xact(u, 1'b0, 3'b001, 12'h020, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h00003344 || er !== 1'b0) begin
      failures++;
      $display("FAIL lh_low u=%0d got rdata=%h err=%b exp 00003344/0", u, rd, er);
    end
    xact(u, 1'b0, 3'b010, 12'h020, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h80013344 || er !== 1'b0) begin
      failures++;
      $display("FAIL lw_after_sh u=%0d got rdata=%h err=%b exp 80013344/0", u, rd, er);
    end
  endtask

  task automatic test_errors(input int u);
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        ew  [6];
    logic [2:0]  ef  [6];
    logic [11:0] ea  [6];
    ew = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    ef = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b001, 3'b101};
    ea = '{12'h011, 12'h023, 12'h010, 12'h010, 12'h021, 12'h020};
    for (int i = 0; i < 6; i++) begin
      xact(u, ew[i], ef[i], ea[i], 32'hFFFFFFFF, rd, er, lat);
      checks++;
      if (rd !== 32'h0 || er !== 1'b1 || lat != u + 1) begin
        failures++;
        $display("FAIL err_req u=%0d i=%0d got rdata=%h err=%b lat=%0d exp 0/1/%0d",
                 u, i, rd, er, lat, u + 1);
      end
    end
    xact(u, 1'b0, 3'b010, 12'h010, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h80000000 || er !== 1'b0) begin
      failures++;
      $display("FAIL err_nowrite10 u=%0d got rdata=%h err=%b exp 80000000/0", u, rd, er);
    end
    xact(u, 1'b0, 3'b010, 12'h020, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h80013344 || er !== 1'b0) begin
      failures++;
      $display("FAIL err_nowrite20 u=%0d got rdata=%h err=%b exp 80013344/0", u, rd, er);
    end
  endtask

  // valid held high across SW/LW pairs; the next request is presented while the block is busy.
  task automatic test_back_to_back(input int u);
    logic        bw  [4];
    logic [11:0] ba  [4];
    logic [31:0] bd  [4];
    logic [31:0] bex [4];
    int          extra;
    bw  = '{1'b1, 1'b0, 1'b1, 1'b0};
    ba  = '{12'h040, 12'h040, 12'h044, 12'h044};
    bd  = '{32'hA5A50001, 32'h0, 32'h5A5A0002, 32'h0};
    bex = '{32'h0, 32'hA5A50001, 32'h0, 32'h5A5A0002};
    @(negedge clk);
    drive(u, bw[0], 3'b010, ba[0], bd[0]);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (u == 1) begin
        checks++;
        if (ready[u] !== 1'b0 || rsp[u] !== 1'b0) begin
          failures++;
          $display("FAIL b2b_busy u=%0d i=%0d got ready=%b rsp=%b exp 0/0", u, i, ready[u], rsp[u]);
        end
      end
      if (i < 3) drive(u, bw[i+1], 3'b010, ba[i+1], bd[i+1]);
      else valid[u] = 1'b0;
      if (u == 1) begin
        @(posedge clk);
        #1;
      end
      checks++;
      if (rsp[u] !== 1'b1 || ready[u] !== 1'b1 || rdata[u] !== bex[i] || err[u] !== 1'b0) begin
        failures++;
        $display("FAIL b2b_rsp u=%0d i=%0d got rsp=%b ready=%b rdata=%h err=%b exp 1/1/%h/0",
                 u, i, rsp[u], ready[u], rdata[u], err[u], bex[i]);
      end
    end
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      if (rsp[u] === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL b2b_extra u=%0d got extra_rsp=%0d exp 0", u, extra);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          pulses;
    xact(1, 1'b1, 3'b010, 12'h050, 32'h12345678, rd, er, lat);
    @(negedge clk);
    drive(1, 1'b0, 3'b010, 12'h050, 32'h0);
    @(posedge clk);
    #1;
    valid[1] = 1'b0;
    checks++;
    if (ready[1] !== 1'b0 || rsp[1] !== 1'b0) begin
      failures++;
      $display("FAIL mid_busy got ready=%b rsp=%b exp 0/0", ready[1], rsp[1]);
    end
    #1;
    rst_n = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (ready[u] !== 1'b0 || rsp[u] !== 1'b0 || rdata[u] !== 32'h0 || err[u] !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_outputs u=%0d got ready=%b rsp=%b rdata=%h err=%b exp all 0",
                 u, ready[u], rsp[u], rdata[u], err[u]);
      end
    end
    pulses = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (rsp[1] === 1'b1) pulses++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ready[1] !== 1'b1) begin
      failures++;
      $display("FAIL mid_release_ready got ready=%b exp 1", ready[1]);
    end
    repeat (3) begin
      if (rsp[1] === 1'b1) pulses++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL mid_dropped_rsp got pulses=%0d exp 0", pulses);
    end
    xact(1, 1'b0, 3'b010, 12'h050, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h12345678 || er !== 1'b0) begin
      failures++;
      $display("FAIL mid_store_kept got rdata=%h err=%b exp 12345678/0", rd, er);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    for (int u = 0; u < 2; u++) begin
      valid[u] = 1'b0;
      we[u]    = 1'b0;
      f3[u]    = 3'b000;
      addr[u]  = 12'h000;
      wdata[u] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    for (int u = 0; u < 2; u++) begin
      test_word(u);
      test_byte(u);
      test_half(u);
      test_errors(u);
      test_back_to_back(u);
    end
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
- Byte-addressable, single-port data memory with a built-in load/store formatter.
- Executes RV32I LB/LH/LW/LBU/LHU/SB/SH/SW directly from funct3. Stores are byte-enabled; loads are sign- or zero-extended.
- Adds a valid/ready request handshake, a configurable read latency and misaligned/illegal-access detection.
- Sits between the RV32I execute stage and the data address space.

Parameters:
- N_WORD, 1024, number of DATA_LEN words; must be a power of two.
- ADDR_W, 12, byte-address width; must equal log2(N_WORD)+2. Mismatch is an elaboration error.
- DATA_LEN, 32, word width; only 32 is supported.
- RD_LAT, 1, request-to-response latency in cycles; legal values are 1 or 2.

Ports:
- d_clk  in  1  clock; all state changes on the rising edge.
- d_rst_n  in  1  reset, asynchronous, active-low.
- d_req_valid  in  1  request present.
- d_req_ready  out  1  block can accept a request this cycle.
- d_we  in  1  1 = store, 0 = load.
- d_funct3  in  3  RV32I load/store funct3.
- d_addr  in  ADDR_W  byte address.
- d_w_data  in  DATA_LEN  store data; the relevant bytes are taken from the LSBs.
- d_rsp_valid  out  1  one-cycle response pulse.
- d_r_data  out  DATA_LEN  formatted load data.
- d_err  out  1  request was misaligned or illegal; qualified by d_rsp_valid.

Behaviour:
- Reset (d_rst_n low, asynchronous):
  - d_req_ready=0, d_rsp_valid=0, d_r_data=0, d_err=0, FSM=IDLE, latency counter=0.
  - Memory contents are not reset. Reads of unwritten words return X.
  - d_req_ready rises in the first cycle after reset deassertion.
- Accept: a request is accepted on a rising edge where d_req_valid && d_req_ready. Word index is d_addr[ADDR_W-1:2]; byte offset is d_addr[1:0].
- funct3 decode:
  - 000 B, 001 H, 010 W (both load and store).
  - 100 BU, 101 HU (load only).
  - Any other value, or 100/101 with d_we=1, is illegal.
- Misaligned accesses: H/HU with addr[0]=1; W with addr[1:0]!=0.
- Error requests (illegal or misaligned): no memory write. Response has d_err=1 and d_r_data=0.
- Stores:
  - Memory is written at the accept edge using byte enables: SB writes byte lane = offset; SH writes lanes {offset+1, offset}; SW writes all lanes.
  - The data byte/half is replicated from d_w_data LSBs onto the selected lanes.
  - The response still pulses, with d_r_data=0.
- Loads:
  - The word is sampled at the accept edge, so it reflects any store accepted on an earlier edge.
  - The selected byte/half is shifted to the LSBs. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- FSM states IDLE, BUSY, RESP:
  - RD_LAT=1: accept moves to RESP. BUSY is never entered.
  - RD_LAT=2: accept moves to BUSY for one cycle, then RESP.
  - d_req_ready=1 in IDLE and RESP, 0 in BUSY.
  - In RESP, d_rsp_valid=1 for exactly one cycle. A new accept in RESP goes back to BUSY/RESP; otherwise the FSM returns to IDLE.
- Throughput: one request per RD_LAT cycles. d_rsp_valid rises exactly RD_LAT edges after the accept edge.
- Response hold: d_r_data and d_err hold their last values while d_rsp_valid=0.
- Only one request is outstanding. d_req_valid while ready=0 is ignored; the requester must hold it.
- Reset mid-operation: the pending response is dropped and no response pulse appears. A store already accepted remains written.

Test Plan:
- SW 0xDEADBEEF @0x010, then LW @0x010 -> rsp d_r_data=0xDEADBEEF, d_err=0, rsp_valid exactly RD_LAT edges after accept.
- SB 0x80 @0x013 over 0x00000000, then LB @0x013 -> 0xFFFFFF80; LBU @0x013 -> 0x00000080; LW @0x010 -> 0x80000000.
- SH 0x8001 @0x022, then LH @0x022 -> 0xFFFF8001; LHU -> 0x00008001; LW @0x020 -> bytes 0-1 unchanged from their prior value.
- LW @0x011, SH @0x023, funct3=011, and SB with funct3=100 -> each gives d_err=1 and d_r_data=0; following LWs show memory unchanged.
- RD_LAT=2 with d_req_valid held high for back-to-back SW/LW pairs -> d_req_ready low every BUSY cycle, one response per 2 cycles, and no request lost or duplicated.
- Assert d_rst_n low between the accept and response of an LW -> no d_rsp_valid pulse; all outputs are 0 during reset; d_req_ready rises the first cycle after release.
